uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/byte_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_DEFAULT_DIV = 868;
  localparam int UART_DATA_BITS   = 8;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous byte FIFO with extra-MSB pointers; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchroniser, baud counter and frame FSM feeding a
// byte FIFO drained through a valid/ready port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_DEFAULT_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  // Handshake: a byte transfers in every cycle with rd_valid && rd_ready;
  // rd_data is stable while rd_valid is high and rd_ready is low.
  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic [1:0]                settle_q, settle_d;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      rx_s;
  logic                      tick;
  logic                      push;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;

  assign rx_s      = sync2_q;
  assign tick      = (cnt_q == '0);
  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE) && (state_q != WAIT_IDLE);

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    // The synchroniser's reset value is not a real line observation, so
    // WAIT_IDLE ignores rx_s until both stages have captured the pin.
    settle_d    = {settle_q[0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: if (rx_s && settle_q[1]) state_d = IDLE;
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else if (!rx_s) begin
          state_d   = DATA;
          cnt_d     = FULL_LOAD;
          bit_idx_d = '0;
        end else state_d = IDLE;
      end
      DATA: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else begin
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      STOP: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    overrun_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      settle_q    <= '0;
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (shreg_q),
    .dout (rd_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames against a byte-stream reference model of
// the UART receiver and its FIFO.
module tb_uart_rx_fifo;

  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 4;
  // Start drive -> 2-cycle synchroniser -> 1 cycle to leave IDLE -> half-bit
  // count to the start sample -> nine more bit periods to the stop sample.
  localparam int STOP_TICK  = 3 + (CLK_DIV / 2 - 1) + 9 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int occ = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int valid_cycles = 0;

  uart_rx_fifo #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Passive observer of the output port.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) got_q.push_back(rd_data);
    if (rd_valid) valid_cycles++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pulse_at);
    logic [9:0] bits;
    int n;
    bits = {stop_b, d, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < CLK_DIV; j++) begin
        @(posedge clk);
        #1;
        n++;
        if (n == pulse_at) rd_ready = 1'b1;
        else if (pulse_at > 0 && n == pulse_at + 1) rd_ready = 1'b0;
      end
    end
  endtask

  // Reference model: what a received frame does to the byte stream.
  task automatic model_rx(input logic [7:0] d, input logic stop_b, input logic draining);
    if (!stop_b) exp_fe++;
    else if (!draining && occ == FIFO_DEPTH) exp_ov++;
    else begin
      exp_q.push_back(d);
      if (!draining) occ++;
    end
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    occ = 0;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_frame_err"}, fe_cnt, exp_fe);
    chk({tag, "_overrun"}, ov_cnt, exp_ov);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int v0;
    int saw;
    logic [7:0] r;
    logic       s;

    reset = 1'b1;
    rx = 1'b1;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);

    // single frame, consumer always ready
    rd_ready = 1'b1;
    v0 = valid_cycles;
    send_frame(8'h55, 1'b1, -1);
    model_rx(8'h55, 1'b1, 1'b1);
    idle(4);
    chk("t1_valid_cycles", valid_cycles - v0, 1);
    chk("t1_busy_after", busy, 0);
    compare_stream("t1");

    // three frames buffered, then drained in order
    rd_ready = 1'b0;
    send_frame(8'hA3, 1'b1, -1); model_rx(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, -1); model_rx(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, -1); model_rx(8'hFF, 1'b1, 1'b0);
    idle(4);
    chk("t2_rd_valid", rd_valid, 1);
    chk("t2_head", rd_data, 8'hA3);
    drain();
    chk("t2_empty_after", rd_valid, 0);
    compare_stream("t2");

    // two-cycle glitch on an idle line
    rx = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) saw = 1;
    end
    @(posedge clk);
    #1;
    chk("t3_busy_pulsed", saw, 1);
    chk("t3_busy_after", busy, 0);
    compare_stream("t3");

    // bad stop bit, line held low, then a good frame
    send_frame(8'h3C, 1'b0, -1);
    model_rx(8'h3C, 1'b0, 1'b1);
    saw = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (busy || rd_valid) saw++;
    end
    chk("t4_quiet_while_low", saw, 0);
    idle(6);
    send_frame(8'h12, 1'b1, -1);
    model_rx(8'h12, 1'b1, 1'b1);
    idle(4);
    compare_stream("t4");

    // overflow: fifth frame dropped
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1);
      model_rx(8'(i), 1'b1, 1'b0);
    end
    idle(4);
    chk("t5_overrun_seen", ov_cnt, exp_ov);
    chk("t5_head", rd_data, 8'h01);
    drain();
    compare_stream("t5");

    // overflow with a pop in the stop-sample cycle of the fifth frame
    rd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, -1);
      model_rx(8'(i), 1'b1, 1'b0);
    end
    send_frame(8'h05, 1'b1, STOP_TICK);
    occ--;
    model_rx(8'h05, 1'b1, 1'b0);
    idle(4);
    chk("t6_no_overrun", ov_cnt, exp_ov);
    chk("t6_head", rd_data, 8'h02);
    drain();
    compare_stream("t6");

    // reset in the middle of a frame with a byte already buffered
    rd_ready = 1'b0;
    r = 8'($urandom_range(0, 255));
    send_frame(r, 1'b1, -1);
    model_rx(r, 1'b1, 1'b0);
    r = 8'h77;
    rx = 1'b0;
    repeat (CLK_DIV) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      rx = r[i];
      repeat (CLK_DIV) begin
        @(posedge clk);
        #1;
      end
    end
    reset = 1'b1;
    rx = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < occ; i++) void'(exp_q.pop_back());
    occ = 0;
    chk("t7_rd_valid", rd_valid, 0);
    chk("t7_busy", busy, 0);
    reset = 1'b0;
    saw = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy || rd_valid || frame_err || overrun) saw++;
    end
    chk("t7_quiet_low_release", saw, 0);
    idle(6);
    rd_ready = 1'b1;
    send_frame(8'h9E, 1'b1, -1);
    model_rx(8'h9E, 1'b1, 1'b1);
    idle(4);
    compare_stream("t7");

    // randomized frames, some with a bad stop bit
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      r = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(r, s, -1);
      model_rx(r, s, 1'b1);
      idle(6);
    end
    idle(4);
    compare_stream("t8");

    chk("err_ovr_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
